// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width / address width
//   regaddr_t / regdata_t           : address and data types at the default widths
//   port_lsb()                      : LSB offset of a port inside a port-packed vector
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] regaddr_t;
  typedef logic [DEFAULT_DATA_W-1:0] regdata_t;

  // Port p of a vector packed as [p*width +: width] starts at this bit.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   clk, reset        : clock, asynchronous active-low reset
//   i_alloc_vld/addr  : decode claims a destination register (sets busy)
//   i_wr_en/i_wr_addr : writeback ports (clear busy of their target)
//   i_rs_addr         : read-port addresses to look up
//   o_rs_busy         : busy flag per read port, from current state
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_alloc_vld,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD-1:0]        o_rs_busy
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [Depth-1:0] r_busy;
  logic [Depth-1:0] w_busy_d;
  logic [Depth-1:0] w_clr;

  always_comb begin
    w_clr = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wr_en[j]) w_clr[i_wr_addr[port_lsb(j, ADDR_W) +: ADDR_W]] = 1'b1;
    end
  end

  // Set after clear: a fresh allocation outranks a retiring producer.
  always_comb begin
    w_busy_d = r_busy & ~w_clr;
    if (i_alloc_vld && !((ZERO_REG != 0) && (i_alloc_addr == '0))) begin
      w_busy_d[i_alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_d;
  end

  // With bypass, a same-cycle clearing write already delivers the value, so mask busy.
  always_comb begin
    o_rs_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      o_rs_busy[i] = r_busy[i_rs_addr[port_lsb(i, ADDR_W) +: ADDR_W]] &
                     ~((BYPASS != 0) & w_clr[i_rs_addr[port_lsb(i, ADDR_W) +: ADDR_W]]);
    end
  end

endmodule

// File: rtl/regfile_mrnw_sb.sv
// Multi-read / multi-write integer register file with bypass and busy scoreboard.
//   clk, reset          : clock, asynchronous active-low reset
//   i_rd_en/i_rs_addr   : per-read-port enable and address (port-packed)
//   o_rs_data           : registered read data, 1-cycle latency, holds when disabled
//   o_rs_busy           : combinational busy flag of each read address
//   i_wr_en/addr/data   : per-write-port write; highest port wins on conflicts
//   i_alloc_vld/addr    : destination allocation (marks register busy)
module regfile_mrnw_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic                     i_alloc_vld,
  input  logic [ADDR_W-1:0]        i_alloc_addr
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [Depth-1:0][DATA_W-1:0] r_regs;
  logic [Depth-1:0][DATA_W-1:0] w_regs_d;
  logic [NUM_RD*DATA_W-1:0]     r_rs_data;
  logic [NUM_RD*DATA_W-1:0]     w_rs_data_d;
  logic [NUM_WR-1:0]            w_wr_ok;

  // A write is live unless it targets the hardwired zero register.
  always_comb begin
    w_wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_wr_ok[j] = i_wr_en[j] &&
                   !((ZERO_REG != 0) && (i_wr_addr[port_lsb(j, ADDR_W) +: ADDR_W] == '0));
    end
  end

  // Per-address loop over ports; later ports overwrite earlier ones.
  always_comb begin
    w_regs_d = r_regs;
    for (int a = 0; a < Depth; a++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wr_ok[j] && (i_wr_addr[port_lsb(j, ADDR_W) +: ADDR_W] == ADDR_W'(a))) begin
          w_regs_d[a] = i_wr_data[port_lsb(j, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_regs <= '0;
    else        r_regs <= w_regs_d;
  end

  // Read mux ahead of the output flop, with same-priority bypass.
  always_comb begin
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rv;
    w_rs_data_d = r_rs_data;
    w_ra        = '0;
    w_rv        = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_ra = i_rs_addr[port_lsb(i, ADDR_W) +: ADDR_W];
      w_rv = r_regs[w_ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_ok[j] && (i_wr_addr[port_lsb(j, ADDR_W) +: ADDR_W] == w_ra)) begin
            w_rv = i_wr_data[port_lsb(j, DATA_W) +: DATA_W];
          end
        end
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) w_rv = '0;
      if (i_rd_en[i]) w_rs_data_d[port_lsb(i, DATA_W) +: DATA_W] = w_rv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rs_data <= '0;
    else        r_rs_data <= w_rs_data_d;
  end

  assign o_rs_data = r_rs_data;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_alloc_vld  (i_alloc_vld),
    .i_alloc_addr (i_alloc_addr),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_rs_addr    (i_rs_addr),
    .o_rs_busy    (o_rs_busy)
  );

endmodule

// File: tb/tb_regfile_mrnw_sb.sv
module tb_regfile_mrnw_sb;

  logic        clk;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rs_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_vld;
  logic [4:0]  alloc_addr;

  logic [63:0] byp_data;
  logic [1:0]  byp_busy;
  logic [63:0] nob_data;
  logic [1:0]  nob_busy;

  int n_cmp;
  int n_err;

  // Bypassing instance: the main device under test.
  regfile_mrnw_sb #(
    .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .BYPASS (1), .ZERO_REG (1)
  ) u_dut_byp (
    .clk          (clk),
    .reset        (reset),
    .i_rd_en      (rd_en),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (byp_data),
    .o_rs_busy    (byp_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_alloc_vld  (alloc_vld),
    .i_alloc_addr (alloc_addr)
  );

  // Non-bypassing instance on the same stimulus.
  regfile_mrnw_sb #(
    .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .BYPASS (0), .ZERO_REG (1)
  ) u_dut_nob (
    .clk          (clk),
    .reset        (reset),
    .i_rd_en      (rd_en),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (nob_data),
    .o_rs_busy    (nob_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_alloc_vld  (alloc_vld),
    .i_alloc_addr (alloc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en     = 2'b00;
    wr_en     = 2'b00;
    wr_addr   = '0;
    wr_data   = '0;
    alloc_vld = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rd_en   = en;
    rs_addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    rs_addr = '0;
    idle();

    // Reset state
    #2;
    check_eq("reset_data", byp_data, 64'h0);
    check_eq("reset_busy", {62'h0, byp_busy}, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: read addr 5 on both ports
    rd(2'b11, 5'd5, 5'd5);
    tick();
    check_eq("t1_data", byp_data, 64'h0);
    check_eq("t1_busy", {62'h0, byp_busy}, 64'h0);

    // 2: write then read, 1-cycle latency
    rd(2'b00, 5'd3, 5'd3);
    wr(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(2'b11, 5'd3, 5'd3);
    tick();
    check_eq("t2_read3", byp_data, {32'hDEADBEEF, 32'hDEADBEEF});
    // rd_en=0 holds while the address moves
    rd(2'b00, 5'd5, 5'd5);
    tick();
    check_eq("t2_hold", byp_data, {32'hDEADBEEF, 32'hDEADBEEF});
    // write to x0 dropped, also in the same-cycle bypass path
    wr(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0);
    rd(2'b10, 5'd5, 5'd0);
    tick();
    check_eq("t2_x0_byp", byp_data, {32'h0, 32'hDEADBEEF});
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(2'b11, 5'd0, 5'd0);
    tick();
    check_eq("t2_x0_read", byp_data, 64'h0);

    // 3: same-cycle write/read, bypass vs no bypass
    wr(2'b01, 5'd7, 32'h1111, 5'd0, 32'h0);
    rd(2'b00, 5'd7, 5'd7);
    tick();
    wr(2'b01, 5'd7, 32'h1234, 5'd0, 32'h0);
    rd(2'b01, 5'd7, 5'd7);
    tick();
    check_eq("t3_bypass", byp_data[31:0], 64'h1234);
    check_eq("t3_nobypass", nob_data[31:0], 64'h1111);

    // 4: write-write conflict, port 1 wins (stored and bypassed)
    wr(2'b11, 5'd9, 32'hAAAA, 5'd9, 32'h5555);
    rd(2'b00, 5'd9, 5'd9);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(2'b01, 5'd9, 5'd9);
    tick();
    check_eq("t4_ww_read", byp_data[31:0], 64'h5555);
    check_eq("t4_ww_nob", nob_data[31:0], 64'h5555);
    wr(2'b11, 5'd9, 32'h1, 5'd9, 32'h2);
    rd(2'b10, 5'd9, 5'd9);
    tick();
    check_eq("t4_ww_byp", byp_data[63:32], 64'h2);
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // 5: scoreboard
    rd(2'b00, 5'd4, 5'd5);
    alloc_vld = 1'b1; alloc_addr = 5'd4;
    #1;
    check_eq("t5_pre_alloc", {62'h0, byp_busy}, 64'h0);
    tick();
    alloc_vld = 1'b0;
    #1;
    check_eq("t5_busy_set", {62'h0, byp_busy}, 64'h1);
    wr(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
    #1;
    check_eq("t5_byp_mask", {62'h0, byp_busy}, 64'h0);
    check_eq("t5_nob_nomask", {62'h0, nob_busy}, 64'h1);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    check_eq("t5_cleared", {62'h0, nob_busy}, 64'h0);
    // alloc and write to 4 together: set wins
    wr(2'b10, 5'd0, 32'h0, 5'd4, 32'h45);
    alloc_vld = 1'b1; alloc_addr = 5'd4;
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    alloc_vld = 1'b0;
    #1;
    check_eq("t5_set_wins", {62'h0, byp_busy}, 64'h1);
    // alloc of x0 ignored
    alloc_vld = 1'b1; alloc_addr = 5'd0;
    tick();
    alloc_vld = 1'b0;
    rd(2'b00, 5'd0, 5'd4);
    #1;
    check_eq("t5_x0_busy", {62'h0, byp_busy}, 64'h2);

    // 6: async reset mid-stream
    rd(2'b11, 5'd3, 5'd4);
    tick();
    check_eq("t6_pre_data", byp_data, {32'h45, 32'hDEADBEEF});
    check_eq("t6_pre_busy", {62'h0, byp_busy}, 64'h2);
    wr(2'b01, 5'd3, 32'h77, 5'd0, 32'h0);
    alloc_vld = 1'b1; alloc_addr = 5'd6;
    #1 reset = 1'b0;
    #1;
    check_eq("t6_async_data", byp_data, 64'h0);
    check_eq("t6_async_busy", {62'h0, byp_busy}, 64'h0);
    tick();
    check_eq("t6_hold_data", byp_data, 64'h0);
    idle();
    reset = 1'b1;
    rd(2'b11, 5'd3, 5'd4);
    tick();
    check_eq("t6_post_data", byp_data, 64'h0);
    rd(2'b00, 5'd6, 5'd4);
    #1;
    check_eq("t6_post_busy", {62'h0, byp_busy}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
